// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage for the CSE141L core.
// It maps the opcode field onto the op_mne code, generates the control strobes,
// and folds the two-word SET sequence (prefix + immediate word) into one output.
// The output register holds one entry and uses a valid/ready handshake with flush.
// Optional feature: define DECODE_STATS_EN to add the saturating stat_decoded and
// stat_stall counters and their output ports.

module decode_stage #(
  parameter int INSTR_W = 9,
  parameter int OP_W    = 4,
  parameter int MNE_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic                      Clk,
  input  logic                      Reset,
`ifdef DECODE_STATS_EN
  output logic [CNT_W-1:0]          stat_decoded,
  output logic [CNT_W-1:0]          stat_stall,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_W-1:0]        in_instr,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MNE_W-1:0]          out_op,
  output logic [INSTR_W-OP_W-1:0]   out_operand,
  output logic [INSTR_W-1:0]        out_imm,
  output logic                      out_is_branch,
  output logic                      out_mem_rd,
  output logic                      out_mem_wr,
  output logic                      out_reg_wr
);

  localparam int OPND_W = INSTR_W - OP_W;

  // Reject parameter sets the encoding cannot support.
  if (INSTR_W < OP_W + 2) begin : g_bad_instr_w
    $error("decode_stage: INSTR_W must be >= OP_W+2");
  end
  if (MNE_W < 5) begin : g_bad_mne_w
    $error("decode_stage: MNE_W must be able to hold SET (16)");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("decode_stage: CNT_W must be >= 1");
  end

  localparam logic [MNE_W-1:0] MNE_MOVE   = MNE_W'(0);
  localparam logic [MNE_W-1:0] MNE_LOAD   = MNE_W'(2);
  localparam logic [MNE_W-1:0] MNE_STORE  = MNE_W'(3);
  localparam logic [MNE_W-1:0] MNE_ADD    = MNE_W'(4);
  localparam logic [MNE_W-1:0] MNE_LSL    = MNE_W'(9);
  localparam logic [MNE_W-1:0] MNE_BRANCH = MNE_W'(10);
  localparam logic [MNE_W-1:0] MNE_BLT    = MNE_W'(15);
  localparam logic [MNE_W-1:0] MNE_SET    = MNE_W'(16);

  typedef enum logic {ST_IDLE, ST_PREFIX} state_e;

  typedef struct packed {
    logic               valid;
    logic [MNE_W-1:0]   op;
    logic [OPND_W-1:0]  operand;
    logic [INSTR_W-1:0] imm;
    logic               is_branch;
    logic               mem_rd;
    logic               mem_wr;
    logic               reg_wr;
  } out_t;

  state_e state_q, state_d;
  out_t   out_q, out_d;

  logic              xfer_in;
  logic              xfer_out;
  logic              is_prefix;
  logic [OP_W-1:0]   opcode;
  logic [OPND_W-1:0] operand;

  assign opcode    = in_instr[INSTR_W-1 -: OP_W];
  assign operand   = in_instr[OPND_W-1:0];
  assign is_prefix = (opcode == '0) && (&operand);

  assign in_ready  = (!out_q.valid || out_ready) && !flush;
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = out_q.valid && out_ready;

  // Next output-register contents and FSM state from the handshake, flush and prefix logic.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    out_d   = out_q;
    if (flush) begin
      state_d = ST_IDLE;
      out_d   = '0;
    end else if (xfer_in) begin
      if (state_q == ST_PREFIX) begin
        state_d       = ST_IDLE;
        out_d         = '0;
        out_d.valid   = 1'b1;
        out_d.op      = MNE_SET;
        out_d.imm     = in_instr;
      end else if (is_prefix) begin
        state_d = ST_PREFIX;
        out_d   = '0;
      end else begin
        out_d         = '0;
        out_d.valid   = 1'b1;
        out_d.op      = MNE_W'(opcode);
        out_d.operand = operand;
      end
    end else if (xfer_out) begin
      out_d = '0;
    end
    // Strobes follow the mnemonic and are forced low whenever nothing valid is held.
    out_d.is_branch = out_d.valid && (out_d.op >= MNE_BRANCH) && (out_d.op <= MNE_BLT);
    out_d.mem_rd    = out_d.valid && (out_d.op == MNE_LOAD);
    out_d.mem_wr    = out_d.valid && (out_d.op == MNE_STORE);
    out_d.reg_wr    = out_d.valid && ((out_d.op <= MNE_LOAD) ||
                                      ((out_d.op >= MNE_ADD) && (out_d.op <= MNE_LSL)) ||
                                      (out_d.op == MNE_SET));
  end

  // Output register and prefix FSM, synchronous active-high reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign out_valid     = out_q.valid;
  assign out_op        = out_q.op;
  assign out_operand   = out_q.operand;
  assign out_imm       = out_q.imm;
  assign out_is_branch = out_q.is_branch;
  assign out_mem_rd    = out_q.mem_rd;
  assign out_mem_wr    = out_q.mem_wr;
  assign out_reg_wr    = out_q.reg_wr;

`ifdef DECODE_STATS_EN
  logic [CNT_W-1:0] stat_decoded_q, stat_decoded_d;
  logic [CNT_W-1:0] stat_stall_q, stat_stall_d;

  // Saturating counters: consumed outputs (flush cycle included) and back-pressured cycles.
  always_comb begin
    stat_decoded_d = stat_decoded_q;
    stat_stall_d   = stat_stall_q;
    if (xfer_out && !(&stat_decoded_q)) stat_decoded_d = stat_decoded_q + 1'b1;
    if (out_q.valid && !out_ready && !(&stat_stall_q)) stat_stall_d = stat_stall_q + 1'b1;
  end

  // Statistics counter registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stat_decoded_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      stat_decoded_q <= stat_decoded_d;
      stat_stall_q   <= stat_stall_d;
    end
  end

  assign stat_decoded = stat_decoded_q;
  assign stat_stall   = stat_stall_q;
`endif

endmodule
